// File: rtl/pshbtn_event_ctrl_pkg.sv
// pshbtn_event_ctrl_pkg
//   Shared definitions for the push-button event controller: the 2-bit
//   state encoding and the FSM state type built on it.
package pshbtn_event_ctrl_pkg;

    localparam logic [1:0] ST_WAIT_REL = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_PRESS    = 2'd2;
    localparam logic [1:0] ST_LONG     = 2'd3;

    typedef enum logic [1:0] {
        WAIT_REL = ST_WAIT_REL,
        IDLE     = ST_IDLE,
        PRESS    = ST_PRESS,
        LONG     = ST_LONG
    } btnState_e;

endpackage

// File: rtl/pshbtn_event_ctrl.sv
// pshbtn_event_ctrl
//   Turns the debounced push-button level into one-cycle short-press,
//   long-press and auto-repeat pulses, and keeps a wrapping demo-mode index
//   (advanced by short presses, cleared by a long press).
//
// Ports:
//   i_Clk        demo clock
//   i_Rst_n      asynchronous active-low reset
//   i_Dbnced     debounced button level (1 = pressed)
//   o_ShortPulse one-cycle pulse on release of a short press
//   o_LongPulse  one-cycle pulse when a hold qualifies as long
//   o_RptPulse   one-cycle pulse every pRptCycles while held after a long press
//   o_Held       high while a press is being tracked (PRESS or LONG)
//   o_Mode       current demo mode index
module pshbtn_event_ctrl
    import pshbtn_event_ctrl_pkg::*;
#(
    parameter int pLongCycles = 8,
    parameter int pRptCycles  = 4,
    parameter int pCntWidth   = 24,
    parameter int pNumModes   = 4,
    parameter int pModeWidth  = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Dbnced,
    output logic                  o_ShortPulse,
    output logic                  o_LongPulse,
    output logic                  o_RptPulse,
    output logic                  o_Held,
    output logic [pModeWidth-1:0] o_Mode
);

    localparam logic [pCntWidth-1:0]  cLongLast = pCntWidth'(pLongCycles - 1);
    localparam logic [pCntWidth-1:0]  cRptLast  = pCntWidth'(pRptCycles - 1);
    localparam logic [pModeWidth-1:0] cModeLast = pModeWidth'(pNumModes - 1);

    btnState_e             rv_State;
    logic [pCntWidth-1:0]  rv_HoldCnt;

    // Reset lands in WAIT_REL so a button held through power-up (or the
    // debouncer's unreset output) cannot fire an event until a release is seen.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rv_State     <= WAIT_REL;
            rv_HoldCnt   <= '0;
            o_ShortPulse <= 1'b0;
            o_LongPulse  <= 1'b0;
            o_RptPulse   <= 1'b0;
            o_Held       <= 1'b0;
            o_Mode       <= '0;
        end else begin
            o_ShortPulse <= 1'b0;
            o_LongPulse  <= 1'b0;
            o_RptPulse   <= 1'b0;
            case (rv_State)
                WAIT_REL: begin
                    if (!i_Dbnced)
                        rv_State <= IDLE;
                end
                IDLE: begin
                    if (i_Dbnced) begin
                        rv_State   <= PRESS;
                        rv_HoldCnt <= '0;
                        o_Held     <= 1'b1;
                    end
                end
                PRESS: begin
                    if (!i_Dbnced) begin
                        rv_State     <= IDLE;
                        o_Held       <= 1'b0;
                        o_ShortPulse <= 1'b1;
                        o_Mode       <= (o_Mode == cModeLast) ? '0 : o_Mode + pModeWidth'(1);
                    end else if (rv_HoldCnt == cLongLast) begin
                        rv_State    <= LONG;
                        rv_HoldCnt  <= '0;
                        o_LongPulse <= 1'b1;
                        o_Mode      <= '0;
                    end else begin
                        rv_HoldCnt <= rv_HoldCnt + pCntWidth'(1);
                    end
                end
                LONG: begin
                    if (!i_Dbnced) begin
                        rv_State <= IDLE;
                        o_Held   <= 1'b0;
                    end else if (rv_HoldCnt == cRptLast) begin
                        rv_HoldCnt <= '0;
                        o_RptPulse <= 1'b1;
                    end else begin
                        rv_HoldCnt <= rv_HoldCnt + pCntWidth'(1);
                    end
                end
                default: rv_State <= WAIT_REL;
            endcase
        end
    end

endmodule
